// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt request priority encoder.
package irq_pkg;

    localparam int IRQ_N = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int IRQ_IDX_W = clog2(IRQ_N);

endpackage

// File: rtl/priority_pick_n.sv
// Combinational find-first-set over N bits, scanning upward from i_offset and wrapping.
module priority_pick_n
    import irq_pkg::*;
#(
    parameter int N = IRQ_N,
    parameter int W = IRQ_IDX_W
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_offset,
    output logic [W-1:0] o_index,
    output logic         o_any
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        int j;
        o_any   = 1'b0;
        o_index = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_offset) + k) % N;
            if (!o_any && i_vec[j]) begin
                o_any   = 1'b1;
                o_index = W'(j);
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// Edge-captured request lines, masked priority select and an ack-held grant.
// Optional macro IRQ_ROUND_ROBIN_EN replaces fixed lowest-index priority with a rotating pointer.
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int N = IRQ_N,
    parameter int W = IRQ_IDX_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    input  logic         clear,
    output logic         valid,
    output logic [W-1:0] index,
    output logic [N-1:0] pending
);

    logic [N-1:0] r_req_q;
    logic [N-1:0] r_pending;
    logic         r_valid;
    logic [W-1:0] r_index;

    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pending_next;
    logic [N-1:0] w_cand;
    logic         w_ack_fire;
    logic [W-1:0] w_offset;
    logic [W-1:0] w_winner;
    logic         w_any;

    assign w_rise     = req & ~r_req_q;
    assign w_ack_fire = r_valid & ack;
    assign w_cand     = r_pending & mask;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            w_clr[i] = clear | (w_ack_fire && (r_index == W'(i)));
        end
    end

    // A rise in the same cycle as its clear keeps the bit pending.
    assign w_pending_next = w_rise | (r_pending & ~w_clr);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [W-1:0] r_rr_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_ack_fire) begin
            r_rr_ptr <= (r_index == W'(N - 1)) ? '0 : r_index + 1'b1;
        end
    end

    assign w_offset = r_rr_ptr;
`else
    assign w_offset = '0;
`endif

    priority_pick_n #(
        .N (N),
        .W (W)
    ) u_pick (
        .i_vec    (w_cand),
        .i_offset (w_offset),
        .o_index  (w_winner),
        .o_any    (w_any)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
        end else begin
            r_req_q   <= req;
            r_pending <= w_pending_next;
            if (clear) begin
                r_valid <= 1'b0;
            end else if (r_valid) begin
                // Held grant is never preempted; an ack opens a one-cycle gap.
                if (ack) begin
                    r_valid <= 1'b0;
                end
            end else if (w_any) begin
                r_valid <= 1'b1;
                r_index <= w_winner;
            end
        end
    end

    assign valid   = r_valid;
    assign index   = r_index;
    assign pending = r_pending;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed self-checking bench for irq_priority_encoder (N=4); round-robin vectors need IRQ_ROUND_ROBIN_EN.
module tb_irq_priority_encoder;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       clear;
    logic       valid;
    logic [1:0] index;
    logic [3:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    irq_priority_encoder dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .clear   (clear),
        .valid   (valid),
        .index   (index),
        .pending (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [1:0] idx,
                               input logic [3:0] pend);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) check({tag, ".index"}, 32'(index), 32'(idx));
        check({tag, ".pending"}, 32'(pending), 32'(pend));
    endtask

    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        mask  = 4'b1111;
        ack   = 1'b0;
        clear = 1'b0;

        repeat (3) tick();
        check("reset.valid", 32'(valid), 32'd0);
        check("reset.index", 32'(index), 32'd0);
        check("reset.pending", 32'(pending), 32'd0);

        // req is dropped before release so the idle check starts from a quiet input.
        req = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_state("idle", 1'b0, 2'd0, 4'b0000);

        // Latency: pending after edge k, grant after edge k+1.
        req = 4'b0100;
        tick();
        check_state("lat.k", 1'b0, 2'd0, 4'b0100);
        req = 4'b0000;
        tick();
        check_state("lat.k1", 1'b1, 2'd2, 4'b0100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("lat.ack", 1'b0, 2'd0, 4'b0000);

        // Higher-priority arrival does not preempt the held grant.
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        check_state("hold.g3", 1'b1, 2'd3, 4'b1000);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check_state("hold.new", 1'b1, 2'd3, 4'b1010);
        tick();
        check_state("hold.still", 1'b1, 2'd3, 4'b1010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("hold.gap", 1'b0, 2'd0, 4'b0010);
        tick();
        check_state("hold.g1", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("hold.done", 1'b0, 2'd0, 4'b0000);

        // Simultaneous rises: lowest index wins.
        req = 4'b0110;
        tick();
        req = 4'b0000;
        tick();
        check_state("prio.low", 1'b1, 2'd1, 4'b0110);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check_state("prio.next", 1'b1, 2'd2, 4'b0100);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Masked line stays pending until unmasked.
        mask = 4'b1110;
        req  = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check_state("mask.blocked", 1'b0, 2'd0, 4'b0001);
        mask = 4'b1111;
        tick();
        check_state("mask.open", 1'b1, 2'd0, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("mask.done", 1'b0, 2'd0, 4'b0000);

        // Ack while idle is ignored.
        req = 4'b0001;
        tick();
        req = 4'b0000;
        ack = 1'b1;
        tick();
        check_state("ackidle.grant", 1'b1, 2'd0, 4'b0001);
        tick();
        ack = 1'b0;
        check_state("ackidle.done", 1'b0, 2'd0, 4'b0000);

        // A line held high requests only once.
        req = 4'b0100;
        tick();
        tick();
        check_state("level.g2", 1'b1, 2'd2, 4'b0100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        check_state("level.once", 1'b0, 2'd0, 4'b0000);
        req = 4'b0000;
        tick();

        // Ack of index 1 while line 1 re-rises: set wins, re-granted after the gap.
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        check_state("reack.g1", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1;
        req = 4'b0010;
        tick();
        ack = 1'b0;
        req = 4'b0000;
        check_state("reack.gap", 1'b0, 2'd0, 4'b0010);
        tick();
        check_state("reack.again", 1'b1, 2'd1, 4'b0010);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Clear drops a held grant and all pending bits.
        req = 4'b0001;
        tick();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        check_state("clr.held", 1'b1, 2'd0, 4'b1001);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_state("clr.done", 1'b0, 2'd0, 4'b0000);
        check("clr.index_kept", 32'(index), 32'd0);
        tick();
        check_state("clr.idle", 1'b0, 2'd0, 4'b0000);

        // Rise in the same cycle as clear still sets its bit.
        clear = 1'b1;
        req   = 4'b0100;
        tick();
        clear = 1'b0;
        req   = 4'b0000;
        check_state("clrrise.set", 1'b0, 2'd0, 4'b0100);
        tick();
        check_state("clrrise.g2", 1'b1, 2'd2, 4'b0100);

        // Reset mid-grant returns everything to reset values at that edge.
        reset = 1'b0;
        tick();
        check("rstmid.valid", 32'(valid), 32'd0);
        check("rstmid.index", 32'(index), 32'd0);
        check("rstmid.pending", 32'(pending), 32'd0);
        reset = 1'b1;
        tick();

`ifdef IRQ_ROUND_ROBIN_EN
        begin
            logic [1:0] exp_seq [5];
            exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            req = 4'b1111;
            tick();
            req = 4'b0000;
            tick();
            for (int s = 0; s < 5; s++) begin
                check($sformatf("rr.seq%0d", s), 32'(valid), 32'd1);
                check($sformatf("rr.idx%0d", s), 32'(index), 32'(exp_seq[s]));
                ack = 1'b1;
                req = 4'b0001 << exp_seq[s];
                tick();
                check($sformatf("rr.pend%0d", s), 32'(pending), 32'hF);
                ack = 1'b0;
                req = 4'b0000;
                tick();
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
